// File: rtl/ifu_fetch.sv
// rtl/ifu_fetch.sv - instruction fetch unit: PC, single-outstanding memory read, decode handshake
module ifu_fetch #(
  parameter int                  PC_WIDTH   = 32,
  parameter int                  INST_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC   = 32'h8000_0000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  output logic                  mem_req_valid,
  input  logic                  mem_req_ready,
  output logic [PC_WIDTH-1:0]   mem_req_addr,
  input  logic                  mem_rsp_valid,
  input  logic [INST_WIDTH-1:0] mem_rsp_data,
  input  logic                  mem_rsp_err,
  output logic                  inst_valid,
  input  logic                  inst_ready,
  output logic [INST_WIDTH-1:0] inst,
  output logic [PC_WIDTH-1:0]   inst_pc,
  input  logic                  redirect_valid,
  input  logic [PC_WIDTH-1:0]   redirect_pc,
  input  logic                  halt,
  output logic                  halted,
  output logic                  fetch_err
);

  typedef enum logic [2:0] {
    S_BOOT  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_HOLD  = 3'd3,
    S_HALT  = 3'd4,
    S_FAULT = 3'd5
  } state_t;

  state_t                state;
  state_t                state_next;
  logic [PC_WIDTH-1:0]   pc;
  logic [PC_WIDTH-1:0]   pc_next;
  logic [PC_WIDTH-1:0]   req_addr;
  logic                  discard;
  logic                  discard_next;
  logic [INST_WIDTH-1:0] inst_q;
  logic [PC_WIDTH-1:0]   inst_pc_q;
  logic [PC_WIDTH-1:0]   redirect_aligned;

  // Targets are always word aligned; the low two bits of the request are dropped.
  assign redirect_aligned = redirect_pc & ~PC_WIDTH'(3);

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_BOOT;
    end else begin
      state <= state_next;
    end
  end

  // Next state plus the next PC and discard flag, which follow the same decisions.
  always_comb begin
    state_next   = state;
    pc_next      = pc;
    discard_next = discard;
    case (state)
      S_BOOT: begin
        state_next = S_REQ;
      end
      S_REQ: begin
        // req_addr stays put; only the PC for the following fetch moves.
        if (redirect_valid) begin
          pc_next      = redirect_aligned;
          discard_next = 1'b1;
        end
        if (mem_req_ready) begin
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect_valid) begin
          pc_next = redirect_aligned;
        end
        if (mem_rsp_valid) begin
          // A redirect arriving with the response retires it just like an earlier one.
          discard_next = 1'b0;
          if (discard || redirect_valid) begin
            state_next = S_REQ;
          end else if (mem_rsp_err) begin
            state_next = S_FAULT;
          end else begin
            state_next = S_HOLD;
          end
        end else if (redirect_valid) begin
          discard_next = 1'b1;
        end
      end
      S_HOLD: begin
        if (inst_ready && halt) begin
          state_next = S_HALT;
        end else if (inst_ready) begin
          state_next = S_REQ;
          pc_next    = redirect_valid ? redirect_aligned : inst_pc_q + PC_WIDTH'(4);
        end else if (redirect_valid) begin
          state_next = S_REQ;
          pc_next    = redirect_aligned;
        end
      end
      default: begin
        state_next = state;
      end
    endcase
  end

  // PC, discard flag, request address and the captured instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc        <= RESET_PC;
      discard   <= 1'b0;
      req_addr  <= '0;
      inst_q    <= '0;
      inst_pc_q <= '0;
    end else begin
      pc      <= pc_next;
      discard <= discard_next;
      if (state_next == S_REQ && state != S_REQ) begin
        req_addr <= pc_next;
      end
      if (state == S_WAIT && state_next == S_HOLD) begin
        inst_q    <= mem_rsp_data;
        inst_pc_q <= req_addr;
      end
    end
  end

  // Outputs decoded from the current state.
  always_comb begin
    mem_req_valid = 1'b0;
    inst_valid    = 1'b0;
    halted        = 1'b0;
    fetch_err     = 1'b0;
    case (state)
      S_REQ:   mem_req_valid = 1'b1;
      S_HOLD:  inst_valid    = 1'b1;
      S_HALT:  halted        = 1'b1;
      S_FAULT: fetch_err     = 1'b1;
      default: mem_req_valid = 1'b0;
    endcase
  end

  assign mem_req_addr = req_addr;
  assign inst         = inst_q;
  assign inst_pc      = inst_pc_q;

endmodule
